// File: rtl/rfphoenix_pit_pkg.sv
// Shared register map, CTRL layout and byte-lane merge helper for the
// rfPhoenix programmable interval timer.
package rfphoenix_pit_pkg;

  localparam logic [3:0]  OFF_CNT   = 4'h0;
  localparam logic [3:0]  OFF_MAX   = 4'h4;
  localparam logic [3:0]  OFF_ONT   = 4'h8;
  localparam logic [3:0]  OFF_CTRL  = 4'hC;

  localparam logic [11:0] ADR_ISR   = 12'h040;
  localparam logic [11:0] ADR_IER   = 12'h044;
  localparam logic [11:0] ADR_LDALL = 12'h048;

  localparam int CTRL_LD = 0;
  localparam int CTRL_CE = 1;
  localparam int CTRL_AR = 2;
  localparam int CTRL_GE = 3;

  typedef struct packed {
    logic ge;
    logic ar;
    logic ce;
    logic ld;
  } ctrl_t;

  function automatic logic [31:0] sel_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  sel);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/rfphoenix_pit_if.sv
// Wishbone responder-side bus bundle for the interval timer.
interface rfphoenix_pit_if;
  logic        cs_i;
  logic        cyc_i;
  logic        stb_i;
  logic        ack_o;
  logic        we_i;
  logic [3:0]  sel_i;
  logic [11:0] adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;

  modport master (output cs_i, cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
                  input  ack_o, dat_o);
  modport slave  (input  cs_i, cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
                  output ack_o, dat_o);
endinterface

// File: rtl/rfphoenix_pit_counter.sv
// One timer channel: CNT/MAX/ONT/CTRL registers, down-count step logic,
// registered duty output and a terminal-event pulse for the ISR.
module rfphoenix_pit_counter import rfphoenix_pit_pkg::*; #(
  parameter int CBITS = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wr_max_i,
  input  logic             wr_ont_i,
  input  logic             wr_ctrl_i,
  input  logic             ld_all_i,
  input  logic [3:0]       sel_i,
  input  logic [31:0]      dat_i,
  input  logic             tick_i,
  input  logic             gate_i,
  output logic [CBITS-1:0] cnt_o,
  output logic [CBITS-1:0] max_o,
  output logic [CBITS-1:0] ont_o,
  output ctrl_t            ctrl_o,
  output logic             out_o,
  output logic             tev_o
);

  logic [CBITS-1:0] cnt_q, cnt_d;
  logic [CBITS-1:0] max_q, max_d;
  logic [CBITS-1:0] ont_q, ont_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             out_q, out_d;
  logic             ctrl_wr, load, ce_kill, step;

  assign ctrl_wr = wr_ctrl_i & sel_i[0];
  assign load    = (ctrl_wr & dat_i[CTRL_LD]) | ld_all_i;
  // Clearing CE by software cancels a step arriving on the same edge.
  assign ce_kill = ctrl_wr & ~dat_i[CTRL_CE];
  assign step    = ctrl_q.ce & ~ce_kill & ~load & tick_i & (~ctrl_q.ge | gate_i);

  always_comb begin
    max_d  = max_q;
    ont_d  = ont_q;
    ctrl_d = ctrl_q;
    cnt_d  = cnt_q;
    tev_o  = 1'b0;
    if (wr_max_i) max_d = CBITS'(sel_merge(32'(max_q), dat_i, sel_i));
    if (wr_ont_i) ont_d = CBITS'(sel_merge(32'(ont_q), dat_i, sel_i));
    if (ctrl_wr) begin
      ctrl_d.ce = dat_i[CTRL_CE];
      ctrl_d.ar = dat_i[CTRL_AR];
      ctrl_d.ge = dat_i[CTRL_GE];
    end
    ctrl_d.ld = 1'b0;
    if (load) begin
      cnt_d = max_q;
    end else if (step) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CBITS'(1);
      end else begin
        tev_o = 1'b1;
        if (ctrl_q.ar) cnt_d = max_q;
        else           ctrl_d.ce = 1'b0;
      end
    end
    out_d = ctrl_q.ce & (cnt_q <= ont_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      max_q  <= '0;
      ont_q  <= '0;
      ctrl_q <= '0;
      out_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      max_q  <= max_d;
      ont_q  <= ont_d;
      ctrl_q <= ctrl_d;
      out_q  <= out_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign max_o  = max_q;
  assign ont_o  = ont_q;
  assign ctrl_o = ctrl_q;
  assign out_o  = out_q;

endmodule

// File: rtl/rfphoenix_pit.sv
// Four-channel interval timer Wishbone responder: bus decode, ack/read
// registers, ISR/IER, gate synchronizers and the per-channel counters.
module rfphoenix_pit import rfphoenix_pit_pkg::*; #(
  parameter int NTIMER = 4,
  parameter int CBITS  = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  rfphoenix_pit_if.slave    bus,
  input  logic [NTIMER-1:0] tick_i,
  input  logic [NTIMER-1:0] gate_i,
  output logic [NTIMER-1:0] out_o,
  output logic              irq_o
);

  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;
  logic [NTIMER-1:0] g1_q, g1_d, g2_q, g2_d;
  logic [NTIMER-1:0] isr_q, isr_d, ier_q, ier_d;
  logic              irq_q, irq_d;
  logic [NTIMER-1:0] tev, wr_max, wr_ont, wr_ctrl, ld_all;
  logic              req, wr, base_ok;
  logic [31:0]       rdata;
  logic [CBITS-1:0]  cnt_rd [NTIMER];
  logic [CBITS-1:0]  max_rd [NTIMER];
  logic [CBITS-1:0]  ont_rd [NTIMER];
  ctrl_t             ctrl_rd [NTIMER];

  // A held strobe re-qualifies only after ack drops, giving 1,0,1 acks.
  assign req     = bus.cs_i & bus.cyc_i & bus.stb_i & ~ack_q;
  assign wr      = req & bus.we_i;
  assign base_ok = (bus.adr_i[11:8] == 4'h0) && (bus.adr_i[1:0] == 2'b00);

  always_comb begin
    wr_max  = '0;
    wr_ont  = '0;
    wr_ctrl = '0;
    ld_all  = '0;
    for (int n = 0; n < NTIMER; n++) begin
      if (wr && base_ok && bus.adr_i[7:4] == 4'(n)) begin
        wr_max[n]  = (bus.adr_i[3:0] == OFF_MAX);
        wr_ont[n]  = (bus.adr_i[3:0] == OFF_ONT);
        wr_ctrl[n] = (bus.adr_i[3:0] == OFF_CTRL);
      end
      if (wr && bus.adr_i == ADR_LDALL && bus.sel_i[0]) ld_all[n] = bus.dat_i[n];
    end
  end

  always_comb begin
    rdata = '0;
    if (base_ok) begin
      for (int n = 0; n < NTIMER; n++) begin
        if (bus.adr_i[7:4] == 4'(n)) begin
          case (bus.adr_i[3:0])
            OFF_CNT:  rdata = 32'(cnt_rd[n]);
            OFF_MAX:  rdata = 32'(max_rd[n]);
            OFF_ONT:  rdata = 32'(ont_rd[n]);
            OFF_CTRL: rdata = 32'(ctrl_rd[n]);
            default:  rdata = '0;
          endcase
        end
      end
    end
    if (bus.adr_i == ADR_ISR) rdata = 32'(isr_q);
    if (bus.adr_i == ADR_IER) rdata = 32'(ier_q);
  end

  always_comb begin
    ack_d = req;
    dat_d = (req & ~bus.we_i) ? rdata : '0;
    g1_d  = gate_i;
    g2_d  = g1_q;
    ier_d = ier_q;
    isr_d = isr_q;
    if (wr && bus.adr_i == ADR_IER && bus.sel_i[0]) ier_d = bus.dat_i[NTIMER-1:0];
    if (wr && bus.adr_i == ADR_ISR && bus.sel_i[0]) isr_d = isr_q & ~bus.dat_i[NTIMER-1:0];
    // Hardware set is applied last so it beats a same-edge clear.
    isr_d = isr_d | tev;
    irq_d = |(isr_q & ier_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      g1_q  <= '0;
      g2_q  <= '0;
      isr_q <= '0;
      ier_q <= '0;
      irq_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
      dat_q <= dat_d;
      g1_q  <= g1_d;
      g2_q  <= g2_d;
      isr_q <= isr_d;
      ier_q <= ier_d;
      irq_q <= irq_d;
    end
  end

  for (genvar n = 0; n < NTIMER; n++) begin : g_ch
    rfphoenix_pit_counter #(.CBITS(CBITS)) u_counter (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .wr_max_i  (wr_max[n]),
      .wr_ont_i  (wr_ont[n]),
      .wr_ctrl_i (wr_ctrl[n]),
      .ld_all_i  (ld_all[n]),
      .sel_i     (bus.sel_i),
      .dat_i     (bus.dat_i),
      .tick_i    (tick_i[n]),
      .gate_i    (g2_q[n]),
      .cnt_o     (cnt_rd[n]),
      .max_o     (max_rd[n]),
      .ont_o     (ont_rd[n]),
      .ctrl_o    (ctrl_rd[n]),
      .out_o     (out_o[n]),
      .tev_o     (tev[n])
    );
  end

  assign bus.ack_o = ack_q;
  assign bus.dat_o = dat_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_rfphoenix_pit.sv
// Scoreboard bench for rfphoenix_pit: a behavioural timer model predicts
// every bus response and the out_o/irq_o pins under directed and random traffic.
module tb_rfphoenix_pit;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic [3:0] tick = '0;
  logic [3:0] gate = '0;
  logic [3:0] out_o;
  logic       irq_o;
  bit         rand_in = 1'b0;

  rfphoenix_pit_if bus();

  rfphoenix_pit #(.NTIMER(4), .CBITS(32)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus),
    .tick_i (tick),
    .gate_i (gate),
    .out_o  (out_o),
    .irq_o  (irq_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int ack_cnt = 0;
  logic [31:0] exp_q[$];

  // Reference model state
  bit [31:0] m_cnt[4], m_max[4], m_ont[4];
  bit [3:0]  m_ce, m_ar, m_ge, m_isr, m_ier, m_g1, m_g2, m_out;
  bit        m_irq, m_ack;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(logic [11:0] a);
    int ch;
    ch = int'(a[7:4]);
    if (a[11:8] != 4'h0 || a[1:0] != 2'b00) return 32'h0;
    if (ch < 4) begin
      case (a[3:0])
        4'h0: return m_cnt[ch];
        4'h4: return m_max[ch];
        4'h8: return m_ont[ch];
        4'hC: return {28'h0, m_ge[ch], m_ar[ch], m_ce[ch], 1'b0};
        default: return 32'h0;
      endcase
    end
    if (a[7:0] == 8'h40) return {28'h0, m_isr};
    if (a[7:0] == 8'h44) return {28'h0, m_ier};
    return 32'h0;
  endfunction

  function automatic bit [31:0] merge(bit [31:0] o, bit [31:0] d, bit [3:0] s);
    bit [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Advance one clock: predict the effect of the inputs present at this edge.
  task automatic step();
    bit [31:0] n_cnt[4], n_max[4], n_ont[4];
    bit [3:0]  n_ce, n_ar, n_ge, n_isr, n_ier, n_out, tev, g_now;
    bit        req, wr, hit, ld, kill, n_irq;
    logic [11:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    if (rand_in) begin
      tick = 4'($urandom);
      gate = 4'($urandom);
    end
    a = bus.adr_i; d = bus.dat_i; s = bus.sel_i; g_now = gate;
    req = bus.cs_i && bus.cyc_i && bus.stb_i && !m_ack;
    wr  = req && bus.we_i;
    if (req) exp_q.push_back(bus.we_i ? 32'h0 : model_read(a));
    n_cnt = m_cnt; n_max = m_max; n_ont = m_ont;
    n_ce = m_ce; n_ar = m_ar; n_ge = m_ge; n_ier = m_ier; tev = '0;
    for (int n = 0; n < 4; n++) begin
      n_out[n] = m_ce[n] && (m_cnt[n] <= m_ont[n]);
      hit  = wr && a[11:8] == 4'h0 && a[1:0] == 2'b00 && int'(a[7:4]) == n;
      ld   = 1'b0;
      kill = 1'b0;
      if (hit && a[3:0] == 4'h4) n_max[n] = merge(m_max[n], d, s);
      if (hit && a[3:0] == 4'h8) n_ont[n] = merge(m_ont[n], d, s);
      if (hit && a[3:0] == 4'hC && s[0]) begin
        n_ce[n] = d[1]; n_ar[n] = d[2]; n_ge[n] = d[3];
        ld = d[0]; kill = !d[1];
      end
      if (wr && a == 12'h048 && s[0] && d[n]) ld = 1'b1;
      if (ld) n_cnt[n] = m_max[n];
      else if (m_ce[n] && !kill && tick[n] && (!m_ge[n] || m_g2[n])) begin
        if (m_cnt[n] != 0) n_cnt[n] = m_cnt[n] - 1;
        else begin
          tev[n] = 1'b1;
          if (m_ar[n]) n_cnt[n] = m_max[n];
          else n_ce[n] = 1'b0;
        end
      end
    end
    n_isr = m_isr;
    if (wr && a == 12'h040 && s[0]) n_isr = n_isr & ~d[3:0];
    n_isr = n_isr | tev;
    if (wr && a == 12'h044 && s[0]) n_ier = d[3:0];
    n_irq = |(m_isr & m_ier);
    @(posedge clk);
    m_cnt = n_cnt; m_max = n_max; m_ont = n_ont;
    m_ce = n_ce; m_ar = n_ar; m_ge = n_ge; m_isr = n_isr; m_ier = n_ier;
    m_out = n_out; m_irq = n_irq; m_ack = req;
    m_g2 = m_g1; m_g1 = g_now;
    #1;
  endtask

  task automatic xfer(bit we, logic [11:0] a, logic [31:0] d, logic [3:0] s, int hold);
    bus.cs_i = 1'b1; bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
    bus.we_i = we; bus.adr_i = a; bus.dat_i = d; bus.sel_i = s;
    repeat (hold) step();
    bus.cs_i = 1'b0; bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
    step();
  endtask

  task automatic wr32(logic [11:0] a, logic [31:0] d);
    xfer(1'b1, a, d, 4'hF, 1);
  endtask

  task automatic rd32(logic [11:0] a);
    xfer(1'b0, a, 32'h0, 4'hF, 1);
  endtask

  // Monitor: pops the scoreboard on every ack, checks idle data and pins.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_ni) begin
        if (bus.ack_o) begin
          ack_cnt++;
          if (exp_q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL ack_unexpected: got ack with empty queue at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            chk("dat_o", bus.dat_o, e);
          end
        end else begin
          chk("dat_idle", bus.dat_o, 32'h0);
        end
        chk("out_o", {28'h0, out_o}, {28'h0, m_out});
        chk("irq_o", {31'h0, irq_o}, {31'h0, m_irq});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks0, r, ch, hold;
    logic [3:0]  s;
    logic [11:0] a;
    bit found;
    bus.cs_i = 0; bus.cyc_i = 0; bus.stb_i = 0; bus.we_i = 0;
    bus.sel_i = '0; bus.adr_i = '0; bus.dat_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;

    // Every register reads zero after reset
    for (int c = 0; c < 4; c++)
      for (int o = 0; o < 4; o++) rd32(12'((c << 4) | (o << 2)));
    rd32(12'h040); rd32(12'h044); rd32(12'h048); rd32(12'h0FC);

    // Channel 0: auto-reload 4..0 with on-time 1
    wr32(12'h004, 32'd4);
    wr32(12'h008, 32'd1);
    tick = 4'b0001;
    wr32(12'h00C, 32'h7);
    for (int i = 0; i < 6; i++) begin rd32(12'h000); step(); end
    rd32(12'h040);

    // W1C of ISR[0] on the same edge as a channel-0 terminal event
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (m_cnt[0] == 0 && m_ce[0]) found = 1'b1;
      else step();
    end
    if (!found) begin
      n_vec++; n_bad++;
      $display("FAIL w1c_setup: terminal state not reached, got cnt %0d", m_cnt[0]);
    end
    xfer(1'b1, 12'h040, 32'h1, 4'h1, 1);
    rd32(12'h040);

    // Channel 1: one-shot from 2, interrupt enabled
    wr32(12'h040, 32'hF);
    wr32(12'h014, 32'd2);
    wr32(12'h044, 32'h2);
    tick = 4'b0011;
    wr32(12'h01C, 32'h3);
    repeat (4) step();
    rd32(12'h010); rd32(12'h01C); rd32(12'h040);
    wr32(12'h040, 32'h2);
    repeat (2) step();

    // Channel 2: gated counting
    tick = 4'b0100;
    gate = 4'b0000;
    wr32(12'h024, 32'd9);
    wr32(12'h028, 32'd3);
    wr32(12'h02C, 32'hB);
    repeat (4) step();
    rd32(12'h020);
    gate = 4'b0100;
    step(); step(); step();
    rd32(12'h020);
    repeat (3) step();
    rd32(12'h020);

    // Channel 3: byte-lane write, held strobe, MAX=0 auto-reload
    wr32(12'h034, 32'h12345678);
    xfer(1'b1, 12'h034, 32'hAABBCCDD, 4'b0001, 1);
    rd32(12'h034);
    acks0 = ack_cnt;
    xfer(1'b0, 12'h034, 32'h0, 4'hF, 4);
    chk("held_stb_acks", 32'(ack_cnt - acks0), 32'd2);
    wr32(12'h034, 32'h0);
    wr32(12'h044, 32'hF);
    tick = 4'b1000;
    wr32(12'h03C, 32'h5);
    repeat (3) step();
    rd32(12'h040);
    wr32(12'h048, 32'hF);
    rd32(12'h000);

    // Randomised traffic with random ticks and gates
    rand_in = 1'b1;
    for (int i = 0; i < 400; i++) begin
      r    = $urandom_range(0, 9);
      ch   = $urandom_range(0, 3);
      s    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      hold = ($urandom_range(0, 7) == 0) ? $urandom_range(2, 4) : 1;
      if ($urandom_range(0, 15) == 0) begin
        bus.cs_i = 0; bus.cyc_i = 1; bus.stb_i = 1; bus.we_i = 0; bus.adr_i = 12'h040;
        step();
        bus.cyc_i = 0; bus.stb_i = 0;
      end
      case (r)
        0: xfer(1'b1, 12'((ch << 4) | 4), 32'($urandom_range(0, 6)), s, hold);
        1: xfer(1'b1, 12'((ch << 4) | 8), 32'($urandom_range(0, 6)), s, hold);
        2: xfer(1'b1, 12'((ch << 4) | 12), 32'($urandom_range(0, 15)), s, hold);
        3: xfer(1'b1, 12'h040, 32'($urandom_range(0, 15)), s, hold);
        4: xfer(1'b1, 12'h044, 32'($urandom_range(0, 15)), s, hold);
        5: xfer(1'b1, 12'h048, 32'($urandom_range(0, 15)), s, hold);
        9: begin
          a = {4'h0, 6'($urandom), 2'b00};
          xfer(1'b0, a, 32'h0, 4'hF, hold);
        end
        default: xfer(1'b0, 12'((ch << 4) | ($urandom_range(0, 3) << 2)), 32'h0, 4'hF, hold);
      endcase
      repeat ($urandom_range(0, 2)) step();
    end
    rd32(12'h040); rd32(12'h044);
    rand_in = 1'b0;
    repeat (4) step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
